strobe_gen: RTL
===============

Name: strobe_gen

Overview:
Programmable periodic strobe generator. It is the parametrised successor to the fixed-count valid-pulse FSM. It emits one-cycle o_valid pulses every (period+1) clocks, supports burst-limited or continuous runs, pause/resume, abort, and completion signalling. It sits between the control/config logic and the sampling/datapath blocks that need a rate-enable tick.

Parameters:
PERIOD_W, 8, width of the period register; max period value 2^PERIOD_W-1.
BURST_W, 8, width of the burst length and strobe counters; burst length 0 means continuous.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
i_start  input  1  start pulse; sampled only in IDLE.
i_stop  input  1  abort; returns to IDLE from any state.
i_enable  input  1  run gate; low pauses the count, high resumes it.
i_period  input  PERIOD_W  strobe spacing minus 1; latched on accepted start.
i_burst_len  input  BURST_W  number of strobes per run, 0 = continuous; latched on accepted start.
o_valid  output  1  registered one-cycle strobe.
o_done  output  1  registered one-cycle pulse, coincident with the last strobe of a burst.
o_busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset (async, high): state=IDLE; counter, strobe count and latched period/burst all 0; o_valid=0, o_done=0, o_busy=0. Reset mid-run aborts immediately with no o_done.
- States: IDLE, RUN, PAUSE. o_busy is decoded directly from the state register.
- IDLE:
  - On i_start=1 and i_stop=0: latch period_q=i_period and burst_q=i_burst_len; counter=0, strobes=0.
  - Next state is RUN if i_enable=1, else PAUSE.
- IDLE, i_start while busy: ignored; no relatch.
- RUN, on each edge:
  - if counter==period_q: counter<=0, o_valid<=1, strobes<=strobes+1.
  - else: counter<=counter+1, o_valid<=0.
- Strobe latency and spacing: the first o_valid is high in the cycle following edge T0+P+1, where T0 is the start edge. Spacing is exactly P+1 cycles. P=0 gives o_valid continuously high.
- Burst end: if burst_q!=0 and the strobe being issued is number burst_q, then o_done<=1 on the same edge as o_valid, and state<=IDLE. o_done is 0 otherwise.
- Continuous mode (burst_q=0): the strobe count saturates at all-ones and never ends the run.
- RUN with i_enable=0: state<=PAUSE; counter and strobes hold; o_valid<=0.
  - If the counter reaches period_q on that same edge, the strobe is still issued: enable is sampled for the next cycle.
- PAUSE with i_enable=1: state<=RUN; counting resumes from the held value. Total enabled cycles between strobes stay P+1.
- i_stop=1 has priority over start, enable and strobe:
  - state<=IDLE; o_valid<=0, o_done<=0; counters cleared.
- Simultaneous i_stop and final strobe: stop wins; no o_valid, no o_done.
- Changes to i_period or i_burst_len during a run have no effect until the next accepted start.
- Arithmetic: counter is PERIOD_W bits, strobes is BURST_W bits, all unsigned. Neither wraps: counter resets at period_q, and strobes saturates.

Optional Feature:
STROBE_PHASE_EN:
- Defined: adds input i_phase [PERIOD_W-1:0]. On an accepted start, counter is loaded with min(i_phase, i_period). The first strobe then occurs P+1-phase cycles after start; later spacing is unchanged.
- Undefined: no i_phase port; counter starts at 0.

Test Plan:
- Reset asserted mid-RUN with P=3 → all outputs 0 within the same cycle, state IDLE, no o_done.
- Start with P=3, burst=0, enable=1 → o_valid high 1 cycle in 4, first at start+4 edges; o_busy stays 1; o_done never asserts.
- Start with P=2, burst=3 → three o_valid pulses 3 cycles apart; o_done coincides with the third; o_busy falls on the same edge.
- Start with P=4, burst=0; drop enable for 5 cycles after 2 counts → no strobe during pause; next strobe 3 enabled cycles after resume.
- P=0, burst=4 → o_valid high 4 consecutive cycles, o_done on the 4th; a second i_start during the run is ignored.
- Stop asserted on the same edge as the final strobe (P=1, burst=2) → no second o_valid, no o_done, IDLE next cycle. With STROBE_PHASE_EN, P=5 and phase=4 → first strobe at start+2 edges.

Source files
------------

// File: rtl/strobe_gen_if.sv
// strobe_gen_if: control/config and strobe signals between the controller and strobe_gen (STROBE_PHASE_EN adds i_phase)
interface strobe_gen_if #(
   parameter int PERIOD_W = 8,
   parameter int BURST_W  = 8
);
   logic                i_start;
   logic                i_stop;
   logic                i_enable;
   logic [PERIOD_W-1:0] i_period;
   logic [BURST_W-1:0]  i_burst_len;
`ifdef STROBE_PHASE_EN
   logic [PERIOD_W-1:0] i_phase;
`endif
   logic                o_valid;
   logic                o_done;
   logic                o_busy;

   modport master (
`ifdef STROBE_PHASE_EN
      output i_phase,
`endif
      output i_start, i_stop, i_enable, i_period, i_burst_len,
      input  o_valid, o_done, o_busy
   );

   modport slave (
`ifdef STROBE_PHASE_EN
      input  i_phase,
`endif
      input  i_start, i_stop, i_enable, i_period, i_burst_len,
      output o_valid, o_done, o_busy
   );
endinterface

// File: rtl/strobe_gen.sv
// strobe_gen: programmable periodic strobe generator with burst/continuous runs, pause, abort; STROBE_PHASE_EN adds a start phase
module strobe_gen #(
   parameter int PERIOD_W = 8,
   parameter int BURST_W  = 8
) (
   input logic         clk,
   input logic         reset,
   strobe_gen_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t              state_q, state_d;
   logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d, cnt_init;
   logic [BURST_W-1:0]  burst_q, burst_d, strobes_q, strobes_d, strobes_inc;
   logic                valid_q, valid_d, done_q, done_d;
   logic                accept, at_period, step, strobe, last;

   assign accept      = state_q == IDLE && bus.i_start && !bus.i_stop;
   assign at_period   = cnt_q == period_q;
   // A RUN edge with enable low still issues a strobe that is due; otherwise enable gates the count
   assign step        = (state_q == RUN && (bus.i_enable || at_period)) || (state_q == PAUSE && bus.i_enable);
   assign strobe      = step && at_period && !bus.i_stop;
   assign strobes_inc = &strobes_q ? strobes_q : strobes_q + BURST_W'(1);
   assign last        = strobe && burst_q != '0 && strobes_inc == burst_q;
`ifdef STROBE_PHASE_EN
   assign cnt_init    = bus.i_phase < bus.i_period ? bus.i_phase : bus.i_period;
`else
   assign cnt_init    = '0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else state_q <= state_d;
   end

   // Next state: stop and burst end return to IDLE, otherwise enable picks RUN or PAUSE
   always_comb begin
      state_d = bus.i_stop || last || (state_q == IDLE && !accept) ? IDLE : bus.i_enable ? RUN : PAUSE;
   end

   // Output decode: next strobe/done values and busy straight from the state register
   always_comb begin
      valid_d    = strobe;
      done_d     = last;
      bus.o_busy = state_q != IDLE;
   end

   // Datapath next values: config latched only on accepted start, counters cleared by stop
   always_comb begin
      period_d  = accept ? bus.i_period : period_q;
      burst_d   = accept ? bus.i_burst_len : burst_q;
      cnt_d     = bus.i_stop || strobe ? '0 : accept ? cnt_init : step ? cnt_q + PERIOD_W'(1) : cnt_q;
      strobes_d = bus.i_stop || accept ? '0 : strobe ? strobes_inc : strobes_q;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_q  <= '0;
         burst_q   <= '0;
         cnt_q     <= '0;
         strobes_q <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         period_q  <= period_d;
         burst_q   <= burst_d;
         cnt_q     <= cnt_d;
         strobes_q <= strobes_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
      end
   end

   assign bus.o_valid = valid_q;
   assign bus.o_done  = done_q;
endmodule
